// File: rtl/network_output_argmax.sv
// Stream argmax classifier: collects N signed words per vector and tracks the running maximum.
// It emits one {index, value} result per vector through a valid/ready handshake.
module network_output_argmax #(
    parameter int T = 16,
    parameter int N = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [T-1:0]         data_in,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [$clog2(N)-1:0] max_index,
    output logic [T-1:0]         max_value,
    output logic [31:0]          vec_count
);

    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [IW-1:0]   r_cnt;
    logic [IW-1:0]   w_cnt_next;
    logic            r_s_ready;
    logic            r_m_valid;
    logic            w_s_ready_next;
    logic            w_m_valid_next;
    logic [T-1:0]    r_max_value;
    logic [IW-1:0]   r_max_index;
    logic [31:0]     r_vec_count;

    logic            w_word_acc;
    logic            w_res_acc;
    logic            w_greater;

    assign w_word_acc = s_valid && r_s_ready;
    assign w_res_acc  = r_m_valid && m_ready;
    assign w_greater  = $signed(data_in) > $signed(r_max_value);

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_s_ready_next = 1'b0;
        w_m_valid_next = 1'b0;
        case (r_state)
            COLLECT: begin
                if (w_word_acc) begin
                    if (r_cnt == LAST) begin
                        w_cnt_next   = '0;
                        w_state_next = EMIT;
                    end else begin
                        w_cnt_next = r_cnt + IW'(1);
                    end
                end
            end
            EMIT: begin
                if (w_res_acc) begin
                    w_state_next = COLLECT;
                end
            end
            default: begin
                w_state_next = COLLECT;
                w_cnt_next   = '0;
            end
        endcase
        // Handshake flags are flopped from the next state, so neither depends on s_valid/m_ready combinationally.
        w_s_ready_next = (w_state_next == COLLECT);
        w_m_valid_next = (w_state_next == EMIT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= COLLECT;
            r_cnt     <= '0;
            r_s_ready <= 1'b0;
            r_m_valid <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_s_ready <= w_s_ready_next;
            r_m_valid <= w_m_valid_next;
        end
    end

    // Word 0 always seeds the maximum; later words replace it only when strictly greater.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_max_value <= '0;
            r_max_index <= '0;
        end else if (w_word_acc) begin
            if ((r_cnt == '0) || w_greater) begin
                r_max_value <= data_in;
                r_max_index <= r_cnt;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vec_count <= '0;
        end else if (w_res_acc) begin
            r_vec_count <= r_vec_count + 32'd1;
        end
    end

    assign s_ready   = r_s_ready;
    assign m_valid   = r_m_valid;
    assign max_index = r_max_index;
    assign max_value = r_max_value;
    assign vec_count = r_vec_count;

endmodule

// File: tb/tb_network_output_argmax.sv
// Scoreboard bench for network_output_argmax: words queued, expected argmax pushed on the
// N-th accepted word, popped and compared on every result handshake.
module tb_network_output_argmax;

    localparam int T  = 16;
    localparam int N  = 16;
    localparam int IW = 4;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [T-1:0]  val;
    } res_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          s_valid;
    logic          s_ready;
    logic [T-1:0]  data_in;
    logic          m_valid;
    logic          m_ready;
    logic [IW-1:0] max_index;
    logic [T-1:0]  max_value;
    logic [31:0]   vec_count;

    network_output_argmax #(.T(T), .N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .data_in   (data_in),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .max_index (max_index),
        .max_value (max_value),
        .vec_count (vec_count)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          exp_vc = 0;
    int          n_res = 0;
    bit          lat_pend = 1'b0;
    logic [T-1:0] tx_q[$];
    logic [T-1:0] vec_buf[$];
    res_t         exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // One bus cycle: inputs change on the falling edge, handshakes resolve on the next rising edge.
    task automatic do_cycle(input int pv, input int pr);
        bit   sv;
        int   best;
        res_t e;
        @(negedge clk);
        if (lat_pend) begin
            check("latency", {31'd0, m_valid}, 32'd1);
            lat_pend = 1'b0;
        end
        sv      = (tx_q.size() > 0) && ($urandom_range(99) < pv);
        s_valid = sv;
        data_in = sv ? tx_q[0] : T'($urandom);
        m_ready = ($urandom_range(99) < pr);
        if (s_valid && s_ready) begin
            vec_buf.push_back(tx_q.pop_front());
            if (vec_buf.size() == N) begin
                best = 0;
                for (int i = 1; i < N; i++)
                    if ($signed(vec_buf[i]) > $signed(vec_buf[best])) best = i;
                e.idx = IW'(best);
                e.val = vec_buf[best];
                exp_q.push_back(e);
                vec_buf.delete();
                lat_pend = 1'b1;
            end
        end
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_result", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("max_index", {28'd0, max_index}, {28'd0, e.idx});
                check("max_value", {16'd0, max_value}, {16'd0, e.val});
                check("vec_count", vec_count, exp_vc);
                if (n_res < 12 || (n_res % 500) == 0)
                    $display("result %0d: index=%0d value=%h vec_count=%0d", n_res, max_index, max_value, vec_count);
                exp_vc++;
                n_res++;
            end
        end
    endtask

    task automatic drain(input int pv, input int pr, input int budget);
        int n = 0;
        while ((tx_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
            do_cycle(pv, pr);
            n++;
        end
        check("drain_left", 32'(tx_q.size() + exp_q.size()), 32'd0);
        @(negedge clk);
        s_valid = 1'b0;
        m_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset   = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        #1;
        check("rst_s_ready",   {31'd0, s_ready}, 32'd0);
        check("rst_m_valid",   {31'd0, m_valid}, 32'd0);
        check("rst_max_index", {28'd0, max_index}, 32'd0);
        check("rst_max_value", {16'd0, max_value}, 32'd0);
        check("rst_vec_count", vec_count, 32'd0);
        tx_q.delete();
        vec_buf.delete();
        exp_q.delete();
        lat_pend = 1'b0;
        exp_vc   = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("rel_s_ready_low", {31'd0, s_ready}, 32'd0);
        @(negedge clk);
        check("rel_s_ready_high", {31'd0, s_ready}, 32'd1);
    endtask

    initial begin
        logic [T-1:0] cap_val;
        logic [IW-1:0] cap_idx;
        int qsz;
        int n;
        reset   = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        data_in = '0;

        // 1: ascending multiples of three
        do_reset();
        for (int k = 0; k < N; k++) tx_q.push_back(T'(k * 3));
        drain(100, 100, 100);
        check("vc_after_t1", vec_count, 32'd1);

        // 2: all equal negative words
        for (int k = 0; k < N; k++) tx_q.push_back(16'hFFFB);
        drain(100, 100, 100);

        // 3: extreme values, then an all-negative vector
        for (int k = 0; k < N; k++) tx_q.push_back(k == 3 ? 16'h8000 : (k == 7 ? 16'h7FFF : 16'h0000));
        for (int k = 0; k < N; k++) tx_q.push_back(k == 9 ? 16'hFFFF : T'(-(k + 2)));
        drain(100, 100, 100);

        // 4: downstream stall with upstream data waiting
        for (int k = 0; k < N; k++) tx_q.push_back(T'($urandom));
        n = 0;
        while (!m_valid && n < 40) begin
            do_cycle(100, 0);
            n++;
        end
        check("stall_reached", {31'd0, m_valid}, 32'd1);
        for (int k = 0; k < N; k++) tx_q.push_back(T'($urandom));
        cap_idx = max_index;
        cap_val = max_value;
        qsz     = tx_q.size();
        repeat (10) begin
            do_cycle(100, 0);
            check("stall_m_valid", {31'd0, m_valid}, 32'd1);
            check("stall_s_ready", {31'd0, s_ready}, 32'd0);
            check("stall_index", {28'd0, max_index}, {28'd0, cap_idx});
            check("stall_value", {16'd0, max_value}, {16'd0, cap_val});
            check("stall_no_consume", 32'(tx_q.size()), 32'(qsz));
        end
        drain(100, 100, 200);

        // 5: reset in the middle of a vector
        for (int k = 0; k < N; k++) tx_q.push_back(T'(16'h7000 + k));
        n = 0;
        while (vec_buf.size() < 7 && n < 50) begin
            do_cycle(100, 100);
            n++;
        end
        check("partial_words", 32'(vec_buf.size()), 32'd7);
        do_reset();
        for (int k = 0; k < N; k++) tx_q.push_back(k == 4 ? 16'h0100 : T'(k * 16));
        drain(100, 100, 100);
        check("vc_after_t5", vec_count, 32'd1);

        // 6: random vectors under random backpressure on both sides
        do_reset();
        for (int v = 0; v < 2500; v++) begin
            bit wide = $urandom_range(1) == 1;
            for (int k = 0; k < N; k++)
                tx_q.push_back(wide ? T'($urandom) : T'($urandom_range(4)) - 16'd2);
        end
        drain(80, 70, 90000);
        check("vc_end", vec_count, 32'd2500);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
